vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Sink end of the team's VGA link: samples incoming active-low hsync/vsync and 1-bit r/g/b at the pixel rate.
- Pixel rate is a one-clock enable strobe produced by the existing clock divider.
- Reconstructs the raster position, measures line length and locks to stable timing.
- Emits per-pixel strobes carrying x/y coordinates and colour to downstream capture/compare logic.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_BP, 48, samples from hsync rising edge (position 0) to first active pixel
- V_ACTIVE, 480, active lines per frame
- V_BP, 33, lines from vsync rising edge (line 0) to first active line
- LOCK_LINES, 4, consecutive equal line lengths required to lock

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate sample strobe, one clock wide
- hsync_n  in  1  horizontal sync, active low, asynchronous to clock
- vsync_n  in  1  vertical sync, active low, asynchronous to clock
- r, g, b  in  1 each  pixel colour
- pix_valid  out  1  one-clock strobe: active pixel sampled
- pix_x  out  10  column of the strobed pixel
- pix_y  out  10  row of the strobed pixel
- pix_rgb  out  3  {r,g,b} of the strobed pixel
- frame_start  out  1  one-clock strobe on vsync rising edge
- locked  out  1  horizontal timing locked
- h_total  out  11  locked line length in samples
- timing_err  out  1  one-clock strobe on loss of lock

Behaviour:
- Reset:
  - Every output is 0 immediately, with no clock required.
  - All counters, flags and synchronizers clear; FSM goes to UNLOCKED.
- Input path:
  - hsync_n, vsync_n, r, g, b pass through a 2-flop synchronizer clocked every cycle.
  - All other logic advances only on cycles with pix_en=1; with pix_en=0, everything holds.
  - Latency: pin to output is 2 synchronizer clocks plus 1 output register clock.
- Edge detection, on a pix_en cycle:
  - h_rise = sync hsync high while the previous sample was low.
  - v_rise is the same test applied to vsync.
- Horizontal position p (11 bits):
  - p = 0 on h_rise, else h_cnt+1.
  - h_cnt saturates at 2047.
  - Measured length L = h_cnt+1, taken at h_rise.
- Vertical count v_cnt (10 bits):
  - v_rise sets v_cnt to 0; v_rise wins over a simultaneous h_rise.
  - Otherwise h_rise increments v_cnt, saturating at 1023.
  - frame_start pulses on v_rise.
- FSM (states UNLOCKED, CHECK, LOCKED):
  - UNLOCKED: the first h_rise sets h_seen. The next h_rise loads ref_len=L, match=1, and moves to CHECK.
  - CHECK, at h_rise:
    - If L==ref_len, match++.
    - When match reaches LOCK_LINES: go to LOCKED, h_total<=ref_len, locked=1.
    - If L!=ref_len: ref_len=L, match=1.
  - LOCKED, at h_rise with L!=ref_len:
    - Pulse timing_err, locked=0, go to CHECK with ref_len=L, match=1.
    - h_total holds its last value.
  - Any state, h_cnt reaching 2047 (hsync missing):
    - Go to UNLOCKED, clear h_seen, locked=0.
    - Pulse timing_err only if the FSM was LOCKED.
- Pixel strobe, registered on a pix_en cycle:
  - Conditions: locked=1, H_BP<=p<H_BP+H_ACTIVE, V_BP<=v_cnt<V_BP+V_ACTIVE, and both syncs high.
  - On strobe: pix_valid=1, pix_x=p-H_BP, pix_y=v_cnt-V_BP, pix_rgb=synced {r,g,b}.
  - pix_valid returns to 0 on the next clock.
  - pix_x, pix_y and pix_rgb hold between strobes.
- Mid-frame reset: restart from UNLOCKED; no pix_valid until relock.

Test Plan:
- Reset asserted mid-operation with no clock edge -> all outputs 0 within the same cycle. Release and idle syncs high -> outputs stay 0 and locked=0.
- 640x480 timing: 800-sample lines with 96 low; 525 lines with 2 low, pix_en every 4 clocks.
  - locked rises 1 clock after the pix_en of the 6th hsync rising edge; h_total=800.
  - No timing_err.
- One full frame with r/g/b driven from a known x/y pattern:
  - Exactly 307200 pix_valid strobes.
  - First strobe is x=0,y=0; last is x=639,y=479; rgb matches the pattern on every strobe.
  - One frame_start per frame.
- Single 801-sample line while locked:
  - One-clock timing_err, locked=0, zero pix_valid.
  - Relock after 4 further equal 800-sample lines; h_total=800.
- hsync held high while locked -> locked drops and timing_err pulses once after 2047 samples. No further timing_err until relocked.
- pix_en held low for 100 clocks mid-line:
  - No strobes during the gap.
  - On resume, pix_x continues from the next column with no skipped or repeated coordinates.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Sink end of the VGA link. Samples active-low hsync/vsync and 1-bit r/g/b
//   at the pixel rate (pix_en strobe), rebuilds the raster position, locks to
//   a stable line length and emits one strobe per active pixel with its
//   coordinates and colour.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   pix_en                one-clock pixel-rate sample strobe
//   hsync_n, vsync_n      syncs, active low, asynchronous to clock
//   r, g, b               pixel colour
//   pix_valid             one-clock strobe: active pixel sampled
//   pix_x, pix_y, pix_rgb column, row and {r,g,b} of the strobed pixel
//   frame_start           one-clock strobe on vsync rising edge
//   locked, h_total       horizontal lock flag and locked line length
//   timing_err            one-clock strobe on loss of lock
module vga_sync_receiver #(
   parameter int H_ACTIVE   = 640,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_BP       = 33,
   parameter int LOCK_LINES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        hsync_n,
   input  logic        vsync_n,
   input  logic        r,
   input  logic        g,
   input  logic        b,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [2:0]  pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic [10:0] h_total,
   output logic        timing_err
);

   localparam int MW = $clog2(LOCK_LINES + 1);

   typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

   logic [4:0]    meta, sync;      // {hsync, vsync, r, g, b}
   logic          hs, vs;
   logic [2:0]    rgb;
   logic          hs_prev, vs_prev;
   logic          h_rise, v_rise, h_miss;
   logic [10:0]   h_cnt, p;
   logic [9:0]    v_cnt, v_nxt;
   logic [11:0]   meas_len, ref_len;
   logic [MW-1:0] match;
   logic          h_seen;
   state_t        state;
   logic          in_h, in_v, strobe;

   assign hs  = sync[4];
   assign vs  = sync[3];
   assign rgb = sync[2:0];

   // 2-flop synchronizer, clocked every cycle regardless of pix_en
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {hsync_n, vsync_n, r, g, b};
         sync <= meta;
      end
   end

   // The previous-sample flops clear on reset, so the first sample after
   // reset with the syncs idling high registers as a rising edge.
   assign h_rise   = pix_en & hs & ~hs_prev;
   assign v_rise   = pix_en & vs & ~vs_prev;
   assign meas_len = {1'b0, h_cnt} + 12'd1;

   always_comb begin
      p = h_cnt;
      if (h_rise)
         p = '0;
      else if (h_cnt != 11'h7FF)
         p = h_cnt + 11'd1;
   end

   // Fires once, on the sample where the line counter arrives at saturation
   assign h_miss = pix_en & ~h_rise & (h_cnt == 11'h7FE);

   // vsync rise wins over a coincident hsync rise
   always_comb begin
      v_nxt = v_cnt;
      if (v_rise)
         v_nxt = '0;
      else if (h_rise && v_cnt != 10'h3FF)
         v_nxt = v_cnt + 10'd1;
   end

   assign in_h   = (p >= 11'(H_BP)) && (p < 11'(H_BP + H_ACTIVE));
   assign in_v   = (v_nxt >= 10'(V_BP)) && (v_nxt < 10'(V_BP + V_ACTIVE));
   assign strobe = pix_en & locked & in_h & in_v & hs & vs;

   // raster position
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else if (pix_en) begin
         hs_prev <= hs;
         vs_prev <= vs;
         h_cnt   <= p;
         v_cnt   <= v_nxt;
      end
   end

   // lock FSM with registered locked / h_total / timing_err
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= UNLOCKED;
         h_seen     <= 1'b0;
         ref_len    <= '0;
         match      <= '0;
         locked     <= 1'b0;
         h_total    <= '0;
         timing_err <= 1'b0;
      end else begin
         timing_err <= 1'b0;
         if (h_miss) begin
            timing_err <= (state == LOCKED);
            state      <= UNLOCKED;
            h_seen     <= 1'b0;
            locked     <= 1'b0;
         end else if (h_rise) begin
            case (state)
               UNLOCKED: begin
                  // first edge only arms; the length it ends is meaningless
                  if (!h_seen) begin
                     h_seen <= 1'b1;
                  end else begin
                     ref_len <= meas_len;
                     match   <= MW'(1);
                     state   <= CHECK;
                  end
               end
               CHECK: begin
                  if (meas_len == ref_len) begin
                     match <= match + 1'b1;
                     if (match == MW'(LOCK_LINES - 1)) begin
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        h_total <= ref_len[10:0];
                     end
                  end else begin
                     ref_len <= meas_len;
                     match   <= MW'(1);
                  end
               end
               LOCKED: begin
                  if (meas_len != ref_len) begin
                     timing_err <= 1'b1;
                     locked     <= 1'b0;
                     state      <= CHECK;
                     ref_len    <= meas_len;
                     match      <= MW'(1);
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end
      end
   end

   // pixel output register; coordinates and colour hold between strobes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         pix_valid   <= 1'b0;
         frame_start <= v_rise;
         if (strobe) begin
            pix_valid <= 1'b1;
            pix_x     <= p[9:0] - 10'(H_BP);
            pix_y     <= v_nxt - 10'(V_BP);
            pix_rgb   <= rgb;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scaled raster (36-sample lines, 15-line frames) so every scenario fits in a
// short run; the receiver is parameterised to the same geometry.
module tb_vga_sync_receiver;

   localparam int HB = 6, HA = 20, HFP = 4, HS = 6;
   localparam int HT = HB + HA + HFP + HS;        // 36
   localparam int VB = 3, VA = 8, VFP = 2, VS = 2;
   localparam int VT = VB + VA + VFP + VS;        // 15

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] rgb;
   } px_t;

   logic        clock = 1'b0;
   logic        reset, pix_en, hsync_n, vsync_n, r, g, b;
   logic        pix_valid, frame_start, locked, timing_err;
   logic [9:0]  pix_x, pix_y;
   logic [2:0]  pix_rgb;
   logic [10:0] h_total;

   px_t sbq[$];
   int  total = 0, bad = 0;
   int  pv_cnt = 0, fs_cnt = 0, terr_cnt = 0;
   logic [9:0] last_x = '0, last_y = '0, first_x = '0, first_y = '0;
   bit  grab_first = 0;

   vga_sync_receiver #(
      .H_ACTIVE(HA), .H_BP(HB), .V_ACTIVE(VA), .V_BP(VB), .LOCK_LINES(4)
   ) dut (
      .clock(clock), .reset(reset), .pix_en(pix_en),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .r(r), .g(g), .b(b),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .locked(locked), .h_total(h_total),
      .timing_err(timing_err)
   );

   always #5 clock = ~clock;

   function automatic logic [2:0] pat(input int s, input int l);
      int t;
      t = s + 3 * l;
      return t[2:0];
   endfunction

   function automatic logic [63:0] outs();
      return 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                  h_total, timing_err});
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // One sample: pins change, settle through the synchronizer, then one
   // pix_en clock. Returns just after the negedge following that clock.
   task automatic step(input logic hs, input logic vs, input logic [2:0] c);
      hsync_n = hs;
      vsync_n = vs;
      {r, g, b} = c;
      repeat (3) @(negedge clock);
      pix_en = 1'b1;
      @(negedge clock);
      pix_en = 1'b0;
      #1;
   endtask

   // Samples s0..s1-1 of line l in a line of length len (hsync low for the
   // last HS samples, vsync low on the last VS lines).
   task automatic run_line(input int l, input int len, input bit exp,
                           input int s0, input int s1, input int gap);
      px_t e;
      int pvb;
      logic hs, vs;
      logic [2:0] c;
      for (int s = s0; s < s1; s++) begin
         hs = (s < len - HS);
         vs = (l < VT - VS);
         c = pat(s, l);
         if (exp && l >= VB && l < VB + VA && s >= HB && s < HB + HA) begin
            e.x = 10'(s - HB);
            e.y = 10'(l - VB);
            e.rgb = c;
            sbq.push_back(e);
         end
         step(hs, vs, c);
         if (s == gap) begin
            pvb = pv_cnt;
            repeat (100) @(negedge clock);
            #1;
            check("gap_no_strobe", 64'(pv_cnt - pvb), 64'(0));
         end
      end
   endtask

   // monitor / scoreboard
   always @(negedge clock) begin
      px_t e;
      if (timing_err) terr_cnt++;
      if (frame_start) fs_cnt++;
      if (pix_valid) begin
         pv_cnt++;
         last_x = pix_x;
         last_y = pix_y;
         if (grab_first) begin
            first_x = pix_x;
            first_y = pix_y;
            grab_first = 0;
         end
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe got x=%0d y=%0d rgb=%0d want none",
                     pix_x, pix_y, pix_rgb);
         end else begin
            e = sbq.pop_front();
            if (pix_x !== e.x || pix_y !== e.y || pix_rgb !== e.rgb) begin
               bad++;
               $display("FAIL pixel got x=%0d y=%0d rgb=%0d want x=%0d y=%0d rgb=%0d",
                        pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
            end
         end
      end
   end

   initial begin
      #400000;
      total++;
      bad++;
      $display("FAIL watchdog timeout got=running want=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int pv0, fs0, te0;
      reset = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
      {r, g, b} = 3'b000;
      repeat (3) @(negedge clock);
      #1;
      check("reset_state", outs(), 64'(0));
      reset = 1'b0;

      // idle high: the first sample after reset counts as the arming edge
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 3'b000);
      check("idle_locked", 64'(locked), 64'(0));
      check("idle_h_total", 64'(h_total), 64'(0));
      check("idle_strobes", 64'(pv_cnt), 64'(0));
      check("idle_terr", 64'(terr_cnt), 64'(0));

      // acquisition: real rises at lines 10..14 -> lock on line 14's rise,
      // which is the 6th detected rising edge
      for (int l = 9; l < 14; l++) run_line(l, HT, 0, 0, HT, -1);
      check("prelock_locked", 64'(locked), 64'(0));
      step(1'b1, 1'b0, pat(0, 14));
      check("lock_6th_rise", 64'(locked), 64'(1));
      check("lock_h_total", 64'(h_total), 64'(HT));
      run_line(14, HT, 1, 1, HT, -1);

      // full frame with pattern
      pv0 = pv_cnt; fs0 = fs_cnt; te0 = terr_cnt;
      grab_first = 1;
      for (int l = 0; l < VT; l++) run_line(l, HT, 1, 0, HT, -1);
      check("frame_strobes", 64'(pv_cnt - pv0), 64'(HA * VA));
      check("frame_start_cnt", 64'(fs_cnt - fs0), 64'(1));
      check("first_x", 64'(first_x), 64'(0));
      check("first_y", 64'(first_y), 64'(0));
      check("last_x", 64'(last_x), 64'(HA - 1));
      check("last_y", 64'(last_y), 64'(VA - 1));
      check("frame_sb_empty", 64'(sbq.size()), 64'(0));
      check("frame_no_terr", 64'(terr_cnt - te0), 64'(0));

      // one line one sample too long while locked
      run_line(0, HT, 1, 0, HT, -1);
      run_line(1, HT + 1, 1, 0, HT + 1, -1);
      te0 = terr_cnt; pv0 = pv_cnt;
      step(1'b1, 1'b1, pat(0, 2));
      check("long_unlocked", 64'(locked), 64'(0));
      check("long_terr", 64'(terr_cnt - te0), 64'(1));
      run_line(2, HT, 0, 1, HT, -1);
      for (int l = 3; l < 6; l++) run_line(l, HT, 0, 0, HT, -1);
      check("long_no_strobe", 64'(pv_cnt - pv0), 64'(0));
      check("long_prerelock", 64'(locked), 64'(0));
      step(1'b1, 1'b1, pat(0, 6));
      check("long_relock", 64'(locked), 64'(1));
      check("long_h_total", 64'(h_total), 64'(HT));
      run_line(6, HT, 1, 1, HT, -1);
      for (int l = 7; l < VT; l++) run_line(l, HT, 1, 0, HT, -1);
      check("long_terr_once", 64'(terr_cnt - te0), 64'(1));

      // pix_en gap mid-line (line 5, after column 4)
      for (int l = 0; l < VT; l++) run_line(l, HT, 1, 0, HT, (l == 5) ? 10 : -1);
      check("gap_sb_empty", 64'(sbq.size()), 64'(0));

      // hsync stuck high while locked
      te0 = terr_cnt;
      step(1'b1, 1'b1, 3'b000);
      for (int k = 1; k < 2047; k++) step(1'b1, 1'b1, 3'b000);
      check("hold_still_locked", 64'(locked), 64'(1));
      step(1'b1, 1'b1, 3'b000);
      check("hold_unlocked", 64'(locked), 64'(0));
      check("hold_terr", 64'(terr_cnt - te0), 64'(1));
      for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 3'b000);
      check("hold_terr_once", 64'(terr_cnt - te0), 64'(1));
      check("hold_still_unlocked", 64'(locked), 64'(0));

      // relock, then reset mid-frame
      for (int l = 9; l < 14; l++) run_line(l, HT, 0, 0, HT, -1);
      step(1'b1, 1'b0, pat(0, 14));
      check("relock_after_hold", 64'(locked), 64'(1));
      run_line(14, HT, 1, 1, HT, -1);
      for (int l = 0; l < 5; l++) run_line(l, HT, 1, 0, HT, -1);
      run_line(5, HT, 1, 0, 11, -1);
      check("prereset_locked", 64'(locked), 64'(1));
      reset = 1'b1;
      #1;
      check("midframe_reset_outs", outs(), 64'(0));
      repeat (2) @(negedge clock);
      reset = 1'b0;
      pv0 = pv_cnt;
      run_line(5, HT, 0, 11, HT, -1);
      for (int l = 6; l < 9; l++) run_line(l, HT, 0, 0, HT, -1);
      check("postreset_no_strobe", 64'(pv_cnt - pv0), 64'(0));
      check("postreset_unlocked", 64'(locked), 64'(0));
      check("final_sb_empty", 64'(sbq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
